// File: rtl/mm_pkg.sv
// Shared constants and the int32 saturating adder for the MM output path.
// Lane geometry, buffer address width and saturation limits live here.
package mm_pkg;

    localparam int MM_DATA_W     = 512;
    localparam int MM_LANE_W     = 32;
    localparam int MM_LANES      = MM_DATA_W / MM_LANE_W;
    localparam int MM_OUT_ADDR_W = 11;
    localparam int MM_CNT_W      = 24;

    localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_MIN = 32'h8000_0000;

    // Overflow only when both operands share a sign the sum does not.
    function automatic logic [31:0] sat_add(
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic [31:0] s;
        s = a + b;
        if ((a[31] == b[31]) && (s[31] != a[31])) begin
            s = a[31] ? SAT_MIN : SAT_MAX;
        end
        return s;
    endfunction

endpackage

// File: rtl/mm_lane_sat_add.sv
// One int32 lane: saturating op + psum, then optional ReLU.
// Purely combinational; the top instantiates one per lane.
module mm_lane_sat_add
    import mm_pkg::*;
(
    input  logic [MM_LANE_W-1:0] op,
    input  logic [MM_LANE_W-1:0] psum,
    input  logic                 relu,
    output logic [MM_LANE_W-1:0] result
);

    logic [MM_LANE_W-1:0] sum;

    // Saturate first, then clamp negatives when ReLU applies.
    always_comb begin
        sum    = sat_add(op, psum);
        result = (relu && sum[MM_LANE_W-1]) ? '0 : sum;
    end

endmodule

// File: rtl/mm_out_accum.sv
// Read-modify-write accumulator into the output feature buffer.
// Three-stage pipe with S2/W forwarding and a completed-output counter.
module mm_out_accum
    import mm_pkg::*;
#(
    parameter int DATA_W = MM_DATA_W,
    parameter int LANE_W = MM_LANE_W,
    parameter int ADDR_W = MM_OUT_ADDR_W,
    parameter int CNT_W  = MM_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  total_out,
    input  logic              relu_en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              in_first,
    input  logic              in_last,
    output logic              buf_rd_en,
    output logic [ADDR_W-1:0] buf_rd_addr,
    input  logic [DATA_W-1:0] buf_rd_data,
    output logic              buf_wr_en,
    output logic [ADDR_W-1:0] buf_wr_addr,
    output logic [DATA_W-1:0] buf_wr_data,
    output logic              busy,
    output logic              done
);

    localparam int LANES = DATA_W / LANE_W;

    logic              busy_q;
    logic              relu_q;
    logic              zero_done_q;
    logic [CNT_W-1:0]  total_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              s1_valid;
    logic              s1_first;
    logic              s1_last;
    logic [ADDR_W-1:0] s1_addr;
    logic [DATA_W-1:0] s1_data;

    logic              s2_valid;
    logic              s2_last;
    logic [ADDR_W-1:0] s2_addr;
    logic [DATA_W-1:0] s2_data;

    logic              w_valid;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;

    logic              accept;
    logic              s1_relu;
    logic              done_cnt;
    logic [DATA_W-1:0] operand;
    logic [DATA_W-1:0] result;

    // A beat arriving together with start belongs to the old job.
    assign accept      = in_valid & busy_q & ~start;
    assign in_ready    = busy_q;
    assign busy        = busy_q;

    assign buf_rd_en   = accept & ~in_first;
    assign buf_rd_addr = buf_rd_en ? in_addr : '0;

    assign buf_wr_en   = s2_valid;
    assign buf_wr_addr = s2_addr;
    assign buf_wr_data = s2_data;

    assign s1_relu     = s1_last & relu_q;

    assign done_cnt    = busy_q & s2_valid & s2_last
                       & ((cnt_q + CNT_W'(1)) == total_q);
    assign done        = zero_done_q | done_cnt;

    // Operand select: S2 is newest, W covers the read-first RAM lag.
    always_comb begin
        if (s1_first) begin
            operand = '0;
        end else if (s2_valid && (s2_addr == s1_addr)) begin
            operand = s2_data;
        end else if (w_valid && (w_addr == s1_addr)) begin
            operand = w_data;
        end else begin
            operand = buf_rd_data;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        mm_lane_sat_add u_lane (
            .op     (operand[g*LANE_W +: LANE_W]),
            .psum   (s1_data[g*LANE_W +: LANE_W]),
            .relu   (s1_relu),
            .result (result[g*LANE_W +: LANE_W])
        );
    end

    // Job config, busy flag and completed-output counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q      <= 1'b0;
            relu_q      <= 1'b0;
            zero_done_q <= 1'b0;
            total_q     <= '0;
            cnt_q       <= '0;
        end else if (start) begin
            busy_q      <= (total_out != '0);
            relu_q      <= relu_en;
            zero_done_q <= (total_out == '0);
            total_q     <= total_out;
            cnt_q       <= '0;
        end else begin
            zero_done_q <= 1'b0;
            if (busy_q && s2_valid && s2_last) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (done_cnt) begin
                busy_q <= 1'b0;
            end
        end
    end

    // Stage valids; start flushes whatever is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            w_valid  <= 1'b0;
        end else if (start) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            w_valid  <= 1'b0;
        end else begin
            s1_valid <= accept;
            s2_valid <= s1_valid;
            w_valid  <= s2_valid;
        end
    end

    // Stage payloads: S1 captures the beat, S2 the sum, W the last write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_addr  <= '0;
            s1_data  <= '0;
            s2_last  <= 1'b0;
            s2_addr  <= '0;
            s2_data  <= '0;
            w_addr   <= '0;
            w_data   <= '0;
        end else begin
            s1_first <= in_first;
            s1_last  <= in_last;
            s1_addr  <= in_addr;
            s1_data  <= in_data;
            s2_last  <= s1_last;
            s2_addr  <= s1_addr;
            s2_data  <= result;
            w_addr   <= s2_addr;
            w_data   <= s2_data;
        end
    end

endmodule

// File: tb/tb_mm_out_accum.sv
// Bench for mm_out_accum: buffer RAM model, sequential-semantics reference,
// directed literal cases and randomized traffic on a small address window.
module tb_mm_out_accum;

    localparam int DW = 512;
    localparam int AW = 11;
    localparam int CW = 24;
    localparam int NL = 16;
    localparam int MA = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] total_out;
    logic          relu_en;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [AW-1:0] in_addr;
    logic          in_first;
    logic          in_last;
    logic          buf_rd_en;
    logic [AW-1:0] buf_rd_addr;
    logic [DW-1:0] buf_rd_data;
    logic          buf_wr_en;
    logic [AW-1:0] buf_wr_addr;
    logic [DW-1:0] buf_wr_data;
    logic          busy;
    logic          done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mm_out_accum dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .total_out   (total_out),
        .relu_en     (relu_en),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_addr     (in_addr),
        .in_first    (in_first),
        .in_last     (in_last),
        .buf_rd_en   (buf_rd_en),
        .buf_rd_addr (buf_rd_addr),
        .buf_rd_data (buf_rd_data),
        .buf_wr_en   (buf_wr_en),
        .buf_wr_addr (buf_wr_addr),
        .buf_wr_data (buf_wr_data),
        .busy        (busy),
        .done        (done)
    );

    // Dual-port, 1-cycle, read-first output buffer.
    logic [DW-1:0] ram [2**AW];
    always @(posedge clk) begin
        if (buf_rd_en) buf_rd_data <= ram[buf_rd_addr];
        if (buf_wr_en) ram[buf_wr_addr] <= buf_wr_data;
    end

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rep(input int v);
        logic [31:0] x;
        x = v;
        return {NL{x}};
    endfunction

    // Reference arithmetic: exact sum in 64 bits, clamp, optional ReLU.
    function automatic logic [DW-1:0] accum(input logic [DW-1:0] op,
                                            input logic [DW-1:0] ps,
                                            input bit relu);
        logic [DW-1:0] r;
        longint s;
        for (int i = 0; i < NL; i++) begin
            s = longint'($signed(op[i*32 +: 32]))
              + longint'($signed(ps[i*32 +: 32]));
            if (s > 64'sd2147483647) s = 64'sd2147483647;
            if (s < -64'sd2147483648) s = -64'sd2147483648;
            if (relu && s < 0) s = 0;
            r[i*32 +: 32] = s[31:0];
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_lane();
        case ($urandom_range(3))
            0: return 32'h7FFF_FF00 + 32'($urandom_range(255));
            1: return 32'h8000_0000 + 32'($urandom_range(255));
            default: return 32'($urandom_range(4000)) - 32'd2000;
        endcase
    endfunction

    // Reference model: each accepted beat sees all earlier beats' results.
    typedef struct {
        int            due;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            last;
    } wr_t;

    wr_t           q[$];
    logic [DW-1:0] logical   [MA];
    logic [DW-1:0] committed [MA];
    bit            mbusy = 0;
    bit            mzero = 0;
    bit            mrelu = 0;
    int            mcnt  = 0;
    int            mtotal = 0;
    int            cyc   = 0;

    logic [DW-1:0] e_op;
    logic [DW-1:0] e_res;
    bit            e_wr, e_done, e_cdone, e_acc;

    always @(negedge clk) begin
        if (rst) begin
            chk("reset_outs", {in_ready, busy, done, buf_rd_en, buf_wr_en,
                               buf_rd_addr, buf_wr_addr}, '0);
            chk("reset_wdata", buf_wr_data, '0);
            q.delete();
            mbusy = 0;
            mzero = 0;
            mcnt  = 0;
            for (int i = 0; i < MA; i++) logical[i] = committed[i];
        end else begin
            e_wr    = (q.size() > 0) && (q[0].due == cyc);
            e_cdone = e_wr && q[0].last && mbusy && (mcnt + 1 == mtotal);
            e_done  = mzero || e_cdone;
            e_acc   = in_valid && mbusy && !start;
            chk("wr_en", buf_wr_en, e_wr);
            if (e_wr) begin
                chk("wr_addr", buf_wr_addr, q[0].addr);
                chk("wr_data", buf_wr_data, q[0].data);
            end
            chk("rd_en", buf_rd_en, e_acc && !in_first);
            if (e_acc && !in_first) chk("rd_addr", buf_rd_addr, in_addr);
            chk("busy", busy, mbusy);
            chk("in_ready", in_ready, mbusy);
            chk("done", done, e_done);
            if (e_wr) begin
                committed[q[0].addr[4:0]] = q[0].data;
                if (q[0].last && mbusy) mcnt++;
                void'(q.pop_front());
            end
            if (e_cdone) mbusy = 0;
            mzero = 0;
            if (start) begin
                q.delete();
                for (int i = 0; i < MA; i++) logical[i] = committed[i];
                mbusy  = (total_out != 0);
                mzero  = (total_out == 0);
                mcnt   = 0;
                mtotal = int'(total_out);
                mrelu  = relu_en;
            end else if (e_acc) begin
                e_op  = in_first ? '0 : logical[in_addr[4:0]];
                e_res = accum(e_op, in_data, in_last && mrelu);
                logical[in_addr[4:0]] = e_res;
                q.push_back('{cyc + 2, in_addr, e_res, in_last});
            end
        end
        cyc++;
    end

    // Write log for the directed literal checks.
    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            done;
    } wl_t;
    wl_t wlog[$];
    always @(negedge clk) begin
        if (!rst && buf_wr_en) wlog.push_back('{buf_wr_addr, buf_wr_data, done});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0;
        in_first = 0;
        in_last  = 0;
        start    = 0;
    endtask

    task automatic do_start(input int tot, input bit relu);
        step();
        idle();
        start     = 1;
        total_out = CW'(tot);
        relu_en   = relu;
        step();
        start = 0;
        wlog.delete();
    endtask

    task automatic beat(input int a, input logic [DW-1:0] d,
                        input bit f, input bit l);
        in_valid = 1;
        in_addr  = AW'(a);
        in_data  = d;
        in_first = f;
        in_last  = l;
        step();
    endtask

    task automatic settle();
        repeat (5) @(negedge clk);
    endtask

    task automatic preload(input int a, input logic [DW-1:0] d);
        ram[a]       = d;
        committed[a] = d;
        logical[a]   = d;
    endtask

    int            ndone;
    logic [DW-1:0] d1, d2, ex;

    initial begin
        rst = 1; start = 0; total_out = '0; relu_en = 0;
        in_valid = 0; in_data = '0; in_addr = '0;
        in_first = 0; in_last = 0; buf_rd_data = '0;
        for (int i = 0; i < 2**AW; i++) begin
            for (int j = 0; j < NL; j++)
                ram[i][j*32 +: 32] = 32'($urandom_range(2000)) - 32'd1000;
            if (i < MA) begin
                committed[i] = ram[i];
                logical[i]   = ram[i];
            end
        end
        repeat (3) step();
        rst = 0;
        step();

        // Single first+last beat.
        do_start(1, 0);
        beat(5, rep(3), 1, 1);
        idle();
        settle();
        chk("t1_nwr", wlog.size(), 1);
        if (wlog.size() > 0) begin
            chk("t1_addr", wlog[0].addr, 5);
            chk("t1_data", wlog[0].data, rep(3));
            chk("t1_done", wlog[0].done, 1);
        end
        chk("t1_busy", busy, 0);

        // Read-modify-write against buffer contents.
        preload(7, rep(10));
        do_start(1, 0);
        in_valid = 1; in_addr = 7; in_data = rep(-4);
        in_first = 0; in_last = 1;
        @(negedge clk);
        chk("t2_rd_en", buf_rd_en, 1);
        chk("t2_rd_addr", buf_rd_addr, 7);
        step();
        idle();
        settle();
        chk("t2_nwr", wlog.size(), 1);
        if (wlog.size() > 0) chk("t2_data", wlog[0].data, rep(6));

        // Back-to-back same address, stale RAM must not leak in.
        preload(9, rep(1000));
        do_start(1, 0);
        beat(9, rep(1), 1, 0);
        beat(9, rep(2), 0, 0);
        beat(9, rep(3), 0, 1);
        idle();
        settle();
        chk("t3_nwr", wlog.size(), 3);
        if (wlog.size() > 2) begin
            chk("t3_w0", wlog[0].data, rep(1));
            chk("t3_w1", wlog[1].data, rep(3));
            chk("t3_w2", wlog[2].data, rep(6));
        end

        // Saturation in both directions.
        d1 = '0; d2 = '0; ex = '0;
        d1[31:0] = 32'h7FFF_FFF0; d2[31:0] = 32'h0000_0020; ex[31:0] = 32'h7FFF_FFFF;
        d1[63:32] = 32'h8000_0005; d2[63:32] = 32'hFFFF_FFF0; ex[63:32] = 32'h8000_0000;
        d1[95:64] = 32'hFFFF_FFF9; ex[95:64] = 32'hFFFF_FFF9;
        do_start(1, 0);
        beat(11, d1, 1, 0);
        beat(11, d2, 0, 1);
        idle();
        settle();
        chk("t4_nwr", wlog.size(), 2);
        if (wlog.size() > 1) chk("t4_sat", wlog[1].data, ex);

        // ReLU on a final partial.
        d1 = '0; ex = '0;
        d1[31:0] = 32'hFFFF_FFF9;
        d1[63:32] = 32'd5; ex[63:32] = 32'd5;
        do_start(1, 1);
        beat(12, d1, 1, 1);
        idle();
        settle();
        chk("t4_nwr_relu", wlog.size(), 1);
        if (wlog.size() > 0) chk("t4_relu", wlog[0].data, ex);

        // Zero outputs requested.
        do_start(0, 0);
        @(negedge clk);
        chk("t0_done", done, 1);
        chk("t0_busy", busy, 0);

        // Four counted outputs interleaved with non-last partials.
        do_start(4, 0);
        for (int k = 0; k < 4; k++) begin
            beat(20 + k, rep(k + 1), 1, 0);
            beat(20 + k, rep(10), 0, 1);
        end
        idle();
        settle();
        ndone = 0;
        foreach (wlog[i]) if (wlog[i].done) ndone++;
        chk("t5_nwr", wlog.size(), 8);
        chk("t5_ndone", ndone, 1);
        if (wlog.size() > 7) chk("t5_done_at_end", wlog[7].done, 1);
        chk("t5_busy", busy, 0);

        // Reset in the middle of a job.
        do_start(50, 0);
        for (int k = 0; k < 3; k++) beat(24, rep(k), k == 0, 0);
        rst = 1;
        @(negedge clk);
        chk("t5_rst_outs", {in_ready, busy, done, buf_rd_en, buf_wr_en}, '0);
        step();
        rst = 0;
        idle();
        step();

        // Randomized jobs, including restarts mid-stream.
        for (int r = 0; r < 14; r++) begin
            do_start((r == 6) ? 0 : int'($urandom_range(10, 1)), 1'($urandom_range(1)));
            for (int c = 0; c < 40; c++) begin
                in_valid = ($urandom_range(99) < 75);
                in_addr  = ($urandom_range(1) == 0) ? AW'($urandom_range(19, 16))
                                                    : AW'($urandom_range(MA - 1));
                in_first = ($urandom_range(3) == 0);
                in_last  = ($urandom_range(2) == 0);
                for (int j = 0; j < NL; j++) in_data[j*32 +: 32] = rand_lane();
                if ((r % 2 == 1) && (c == 20)) begin
                    start     = 1;
                    total_out = CW'($urandom_range(8, 1));
                    relu_en   = 1'($urandom_range(1));
                end
                step();
                start = 0;
            end
            idle();
            if (r % 3 != 0) repeat (3) step();
        end
        idle();
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
